sb_irq_ctrl: RTL and testbench

System-bus interrupt controller that sits directly downstream of the timer and other bus peripherals and directly upstream of the core's trap logic. It captures one-cycle or level interrupt requests from up to `N_IRQ` sources into a pending register and applies a per-line enable mask. It selects the highest-priority enabled pending line, presents a single interrupt with its cause to the core, and holds it until the core signals return. The core configures it through the same req/write-enable system-bus slave protocol used by the other peripherals.

---
 rtl/sb_irq_ctrl.sv | 153 +++++++++++++++
 tb/tb_sb_irq_ctrl.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sb_irq_ctrl.sv
// System-bus interrupt controller: pending/mask registers, lowest-index-wins arbitration and a
// single outstanding interrupt to the core. Define SB_IRQ_CTRL_EDGE_EN for rising-edge capture.
module sb_irq_ctrl #(
    parameter int unsigned N_IRQ      = 16,
    parameter logic [31:0] CAUSE_BASE = 32'h8000_0010
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             req_i,
    input  logic             write_enable_i,
    input  logic [31:0]      addr_i,
    input  logic [31:0]      write_data_i,
    output logic [31:0]      read_data_o,
    output logic             ready_o,
    input  logic [N_IRQ-1:0] irq_req_i,
    input  logic             irq_ret_i,
    output logic             irq_o,
    output logic [31:0]      irq_cause_o,
    output logic [N_IRQ-1:0] irq_ack_o
);

    localparam logic [31:0] AddrPending = 32'h0000_0000;
    localparam logic [31:0] AddrMask    = 32'h0000_0004;
    localparam logic [31:0] AddrActive  = 32'h0000_0008;
    localparam logic [31:0] AddrSwtrig  = 32'h0000_000C;
    localparam logic [31:0] AddrSoftrst = 32'h0000_0024;

    typedef enum logic {StIdle, StActive} state_e;

    state_e           state_q;
    logic [N_IRQ-1:0] pending_q;
    logic [N_IRQ-1:0] mask_q;
    logic [N_IRQ-1:0] ack_q;
    logic [4:0]       id_q;
    logic             irq_q;
    logic [31:0]      cause_q;

    logic             wr_en;
    logic             wr_pending;
    logic             wr_mask;
    logic             wr_swtrig;
    logic             wr_softrst;
    logic [N_IRQ-1:0] wdata_lines;
    logic [N_IRQ-1:0] w1c_lines;
    logic [N_IRQ-1:0] set_lines;
    logic [N_IRQ-1:0] capture;
    logic [N_IRQ-1:0] eligible;
    logic [N_IRQ-1:0] take;
    logic [N_IRQ-1:0] pending_d;
    logic             win_valid;
    logic [4:0]       win_id;
    logic             unused_wdata;

    assign wr_en       = req_i & write_enable_i;
    assign wr_pending  = wr_en & (addr_i == AddrPending);
    assign wr_mask     = wr_en & (addr_i == AddrMask);
    assign wr_swtrig   = wr_en & (addr_i == AddrSwtrig);
    assign wr_softrst  = wr_en & (addr_i == AddrSoftrst);
    assign wdata_lines = write_data_i[N_IRQ-1:0];
    assign unused_wdata = ^write_data_i;

`ifdef SB_IRQ_CTRL_EDGE_EN
    logic [N_IRQ-1:0] req_hist_q;

    // History starts at 0 so a line already high out of reset still pends once.
    always_ff @(posedge clk_i) begin
        if (rst_i || wr_softrst) begin
            req_hist_q <= '0;
        end else begin
            req_hist_q <= irq_req_i;
        end
    end

    assign capture = irq_req_i & ~req_hist_q;
`else
    assign capture = irq_req_i;
`endif

    assign eligible = pending_q & mask_q;

    // Scan downwards so the lowest eligible index is the last one written.
    always_comb begin
        win_valid = 1'b0;
        win_id    = '0;
        for (int i = int'(N_IRQ) - 1; i >= 0; i--) begin
            if (eligible[i]) begin
                win_valid = 1'b1;
                win_id    = 5'(i);
            end
        end
    end

    assign take      = (state_q == StIdle && win_valid) ? (N_IRQ'(1) << win_id) : '0;
    assign w1c_lines = wr_pending ? wdata_lines : '0;
    assign set_lines = capture | (wr_swtrig ? wdata_lines : '0);
    // Sets are OR-ed in last so they win over a same-cycle W1C or take.
    assign pending_d = (pending_q & ~take & ~w1c_lines) | set_lines;

    always_ff @(posedge clk_i) begin
        if (rst_i || wr_softrst) begin
            state_q   <= StIdle;
            pending_q <= '0;
            mask_q    <= '0;
            ack_q     <= '0;
            id_q      <= '0;
            irq_q     <= 1'b0;
            cause_q   <= '0;
        end else begin
            pending_q <= pending_d;
            ack_q     <= take;
            if (wr_mask) begin
                mask_q <= wdata_lines;
            end
            case (state_q)
                StIdle: begin
                    if (win_valid) begin
                        state_q <= StActive;
                        id_q    <= win_id;
                        irq_q   <= 1'b1;
                        cause_q <= CAUSE_BASE + 32'(win_id);
                    end
                end
                StActive: begin
                    if (irq_ret_i) begin
                        state_q <= StIdle;
                        id_q    <= '0;
                        irq_q   <= 1'b0;
                        cause_q <= '0;
                    end
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    always_comb begin
        read_data_o = '0;
        case (addr_i)
            AddrPending: read_data_o = 32'(pending_q);
            AddrMask:    read_data_o = 32'(mask_q);
            AddrActive:  read_data_o = {irq_q, 26'b0, id_q};
            default:     read_data_o = '0;
        endcase
    end

    assign ready_o     = req_i;
    assign irq_o       = irq_q;
    assign irq_cause_o = cause_q;
    assign irq_ack_o   = ack_q;

endmodule

// File: tb/tb_sb_irq_ctrl.sv
// Bench for sb_irq_ctrl: directed vector table, a held-line sequence and randomized traffic
// checked against a rule-level model. Honours SB_IRQ_CTRL_EDGE_EN like the design.
module tb_sb_irq_ctrl;

    localparam int unsigned N  = 16;
    localparam logic [31:0] CB = 32'h8000_0010;

    localparam logic [31:0] A_PEND = 32'h00;
    localparam logic [31:0] A_MASK = 32'h04;
    localparam logic [31:0] A_ACT  = 32'h08;
    localparam logic [31:0] A_SW   = 32'h0C;
    localparam logic [31:0] A_SRST = 32'h24;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          req = 1'b0;
    logic          we = 1'b0;
    logic [31:0]   addr = '0;
    logic [31:0]   wdata = '0;
    logic [31:0]   rdata;
    logic          ready;
    logic [N-1:0]  irq_req = '0;
    logic          irq_ret = 1'b0;
    logic          irq;
    logic [31:0]   cause;
    logic [N-1:0]  ack;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    sb_irq_ctrl #(.N_IRQ(N), .CAUSE_BASE(CB)) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .req_i         (req),
        .write_enable_i(we),
        .addr_i        (addr),
        .write_data_i  (wdata),
        .read_data_o   (rdata),
        .ready_o       (ready),
        .irq_req_i     (irq_req),
        .irq_ret_i     (irq_ret),
        .irq_o         (irq),
        .irq_cause_o   (cause),
        .irq_ack_o     (ack)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at %0t: got %h, want %h", name, $time, act, exp);
        end
    endtask

    // Reference model: the controller described as "which lines are pending/enabled, is a line
    // in service and which one", advanced once per rising edge.
    typedef struct packed {
        logic [N-1:0] pend;
        logic [N-1:0] mask;
        logic [N-1:0] hist;
        logic         act;
        int           id;
        int           ack_line;
    } mdl_t;

    mdl_t m;

    function automatic mdl_t mdl_reset();
        mdl_t r;
        r.pend = '0;
        r.mask = '0;
        r.hist = '0;
        r.act = 1'b0;
        r.id = 0;
        r.ack_line = -1;
        return r;
    endfunction

    function automatic mdl_t mdl_next(mdl_t s, logic r, logic rq, logic w, logic [31:0] a,
                                      logic [31:0] wd, logic [N-1:0] lines, logic ret);
        mdl_t n = s;
        int taken = -1;
        bit wr = rq && w;
        if (r || (wr && a == A_SRST)) return mdl_reset();
        n.ack_line = -1;
        if (!s.act) begin
            for (int k = 0; k < int'(N); k++) begin
                if (s.pend[k] && s.mask[k]) begin
                    taken = k;
                    break;
                end
            end
            if (taken >= 0) begin
                n.act = 1'b1;
                n.id = taken;
                n.ack_line = taken;
            end
        end else if (ret) begin
            n.act = 1'b0;
            n.id = 0;
        end
        for (int k = 0; k < int'(N); k++) begin
            bit set_k;
            bit clr_k;
`ifdef SB_IRQ_CTRL_EDGE_EN
            set_k = lines[k] && !s.hist[k];
`else
            set_k = lines[k];
`endif
            if (wr && a == A_SW && wd[k]) set_k = 1'b1;
            clr_k = (k == taken) || (wr && a == A_PEND && wd[k]);
            if (set_k) n.pend[k] = 1'b1;
            else if (clr_k) n.pend[k] = 1'b0;
        end
        if (wr && a == A_MASK) n.mask = wd[N-1:0];
        n.hist = lines;
        return n;
    endfunction

    function automatic logic [31:0] mdl_read(mdl_t s, logic [31:0] a);
        if (a == A_PEND) return 32'(s.pend);
        if (a == A_MASK) return 32'(s.mask);
        if (a == A_ACT) return s.act ? (32'h8000_0000 | 32'(s.id)) : 32'h0;
        return 32'h0;
    endfunction

    always @(posedge clk) m <= mdl_next(m, rst, req, we, addr, wdata, irq_req, irq_ret);

    typedef struct packed {
        logic         rst;
        logic         rq;
        logic         we;
        logic [31:0]  addr;
        logic [31:0]  wd;
        logic [N-1:0] lines;
        logic         ret;
        logic         chk;
        logic         irq_e;
        logic [31:0]  cause_e;
        logic [N-1:0] ack_e;
        logic [31:0]  rd_e;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic r, input logic rq, input logic w, input logic [31:0] a,
                       input logic [31:0] wd, input logic [N-1:0] lines, input logic ret,
                       input logic chk, input logic irq_e, input logic [31:0] cause_e,
                       input logic [N-1:0] ack_e, input logic [31:0] rd_e);
        vec_t v;
        v = '{r, rq, w, a, wd, lines, ret, chk, irq_e, cause_e, ack_e, rd_e};
        vecs.push_back(v);
    endtask

    logic [31:0] addr_pool[8] = '{A_PEND, A_MASK, A_ACT, A_SW, A_SRST, 32'h10, 32'h40,
                                   32'h1000_0004};
    int          acks;
    logic [N-1:0] ack_e;

    initial begin
        // Outputs are those of the cycle in which the vector's inputs are applied.
        // Single pulse on line 0 with MASK=1.
        add(1, 0, 0, A_PEND, 0,      0,     0, 0, 0, 0,      0,     0);
        add(0, 1, 1, A_MASK, 1,      0,     0, 1, 0, 0,      0,     0);
        add(0, 0, 0, A_PEND, 0,      'h1,   0, 1, 0, 0,      0,     0);
        add(0, 0, 0, A_PEND, 0,      0,     0, 1, 0, 0,      0,     'h1);
        add(0, 0, 0, A_PEND, 0,      0,     0, 1, 1, CB,     'h1,   0);
        add(0, 0, 0, A_ACT,  0,      0,     0, 1, 1, CB,     0,     32'h8000_0000);
        add(0, 0, 0, A_ACT,  0,      0,     1, 1, 1, CB,     0,     32'h8000_0000);
        add(0, 0, 0, A_ACT,  0,      0,     0, 1, 0, 0,      0,     0);
        // Lines 3 and 5 together: 3 first, one idle cycle, then 5.
        add(0, 1, 1, A_MASK, 'hFFFF, 0,     0, 1, 0, 0,      0,     'h1);
        add(0, 0, 0, A_PEND, 0,      'h28,  0, 1, 0, 0,      0,     0);
        add(0, 0, 0, A_PEND, 0,      0,     0, 1, 0, 0,      0,     'h28);
        add(0, 0, 0, A_PEND, 0,      0,     0, 1, 1, CB + 3, 'h8,   'h20);
        add(0, 0, 0, A_PEND, 0,      0,     1, 1, 1, CB + 3, 0,     'h20);
        add(0, 0, 0, A_PEND, 0,      0,     0, 1, 0, 0,      0,     'h20);
        add(0, 0, 0, A_PEND, 0,      0,     0, 1, 1, CB + 5, 'h20,  0);
        add(0, 0, 0, A_PEND, 0,      0,     1, 1, 1, CB + 5, 0,     0);
        add(0, 0, 0, A_PEND, 0,      0,     0, 1, 0, 0,      0,     0);
        // Masked line 2 stays pending until MASK enables it.
        add(0, 1, 1, A_MASK, 0,      0,     0, 1, 0, 0,      0,     'hFFFF);
        add(0, 0, 0, A_PEND, 0,      'h4,   0, 1, 0, 0,      0,     0);
        add(0, 0, 0, A_PEND, 0,      0,     0, 1, 0, 0,      0,     'h4);
        add(0, 0, 0, A_PEND, 0,      0,     0, 1, 0, 0,      0,     'h4);
        add(0, 1, 1, A_MASK, 'h4,    0,     0, 1, 0, 0,      0,     0);
        add(0, 0, 0, A_PEND, 0,      0,     0, 1, 0, 0,      0,     'h4);
        add(0, 0, 0, A_ACT,  0,      0,     0, 1, 1, CB + 2, 'h4,   32'h8000_0002);
        add(0, 0, 0, A_ACT,  0,      0,     1, 1, 1, CB + 2, 0,     32'h8000_0002);
        add(0, 0, 0, A_PEND, 0,      0,     0, 1, 0, 0,      0,     0);
        // Capture beats same-cycle W1C; SWTRIG on line 3.
        add(0, 1, 1, A_PEND, 'h2,    'h2,   0, 1, 0, 0,      0,     0);
        add(0, 0, 0, A_PEND, 0,      0,     0, 1, 0, 0,      0,     'h2);
        add(0, 1, 1, A_PEND, 'h2,    0,     0, 1, 0, 0,      0,     'h2);
        add(0, 0, 0, A_PEND, 0,      0,     0, 1, 0, 0,      0,     0);
        add(0, 1, 1, A_MASK, 'h8,    0,     0, 1, 0, 0,      0,     'h4);
        add(0, 1, 1, A_SW,   'h8,    0,     0, 1, 0, 0,      0,     0);
        add(0, 0, 0, A_PEND, 0,      0,     0, 1, 0, 0,      0,     'h8);
        add(0, 0, 0, A_PEND, 0,      0,     0, 1, 1, CB + 3, 'h8,   0);
        add(0, 0, 0, A_PEND, 0,      0,     1, 1, 1, CB + 3, 0,     0);
        add(0, 0, 0, A_PEND, 0,      0,     0, 1, 0, 0,      0,     0);
        // SOFTRST while line 0 is active and line 3 pending.
        add(0, 1, 1, A_MASK, 'h1,    0,     0, 1, 0, 0,      0,     'h8);
        add(0, 0, 0, A_PEND, 0,      'h1,   0, 1, 0, 0,      0,     0);
        add(0, 0, 0, A_PEND, 0,      'h8,   0, 1, 0, 0,      0,     'h1);
        add(0, 1, 1, A_SRST, 0,      0,     0, 1, 1, CB,     'h1,   0);
        add(0, 0, 0, A_PEND, 0,      0,     0, 1, 0, 0,      0,     0);
        add(0, 0, 0, A_MASK, 0,      0,     1, 1, 0, 0,      0,     0);
        add(0, 0, 0, A_ACT,  0,      0,     0, 1, 0, 0,      0,     0);
        add(0, 0, 0, A_PEND, 0,      'h1,   0, 1, 0, 0,      0,     0);
        add(0, 1, 1, A_PEND, '1,     0,     0, 1, 0, 0,      0,     'h1);
        add(0, 0, 0, A_PEND, 0,      0,     0, 1, 0, 0,      0,     0);

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            rst = vecs[i].rst;
            req = vecs[i].rq;
            we = vecs[i].we;
            addr = vecs[i].addr;
            wdata = vecs[i].wd;
            irq_req = vecs[i].lines;
            irq_ret = vecs[i].ret;
            #1;
            if (vecs[i].chk) begin
                check($sformatf("vec%0d irq", i), 32'(irq), 32'(vecs[i].irq_e));
                check($sformatf("vec%0d cause", i), cause, vecs[i].cause_e);
                check($sformatf("vec%0d ack", i), 32'(ack), 32'(vecs[i].ack_e));
                check($sformatf("vec%0d rdata", i), rdata, vecs[i].rd_e);
            end
        end

        // Line 4 held high for 20 cycles; the core returns as soon as it sees irq_o.
        @(negedge clk);
        req = 1'b1;
        we = 1'b1;
        addr = A_MASK;
        wdata = 32'h10;
        irq_req = '0;
        irq_ret = 1'b0;
        acks = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (ack[4]) acks++;
            req = 1'b0;
            we = 1'b0;
            addr = A_PEND;
            irq_req = (i < 20) ? N'(32'h10) : '0;
            irq_ret = irq;
        end
        @(negedge clk);
        irq_ret = 1'b0;
        #1;
`ifdef SB_IRQ_CTRL_EDGE_EN
        check("held_line_acks", 32'(acks), 32'd1);
`else
        check("held_line_acks", 32'(acks), 32'd11);
`endif
        check("held_line_pending", rdata, 32'h0);
        check("held_line_irq", 32'(irq), 32'h0);

        // Randomized traffic against the model.
        for (int c = 0; c < 1500; c++) begin
            @(negedge clk);
            rst = (c == 0) || ($urandom_range(0, 299) == 0);
            req = ($urandom_range(0, 2) == 0);
            we = 1'($urandom_range(0, 1));
            addr = addr_pool[$urandom_range(0, 7)];
            if (addr == A_SRST && $urandom_range(0, 7) != 0) addr = A_ACT;
            wdata = $urandom;
            if ($urandom_range(0, 1) == 1) wdata = wdata & $urandom;
            irq_req = N'($urandom & $urandom & $urandom);
            irq_ret = irq ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 15) == 0);
            #1;
            ack_e = '0;
            if (m.ack_line >= 0) ack_e[m.ack_line] = 1'b1;
            check($sformatf("rnd%0d irq", c), 32'(irq), 32'(m.act));
            check($sformatf("rnd%0d cause", c), cause, m.act ? CB + 32'(m.id) : 32'h0);
            check($sformatf("rnd%0d ack", c), 32'(ack), 32'(ack_e));
            check($sformatf("rnd%0d ready", c), 32'(ready), 32'(req));
            check($sformatf("rnd%0d rdata", c), rdata, mdl_read(m, addr));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
